// File: rtl/alu_issue_queue.sv
// Issue queue for ALU operations. A FIFO feeds the head entry to an external
// combinational ALU, and a registered writeback stage captures the result.
module alu_issue_queue #(
  parameter int OPERANDSIZE = 64,
  parameter int DEPTH       = 4,
  parameter int TAGWIDTH    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [11:0]              in_op,
  input  logic [OPERANDSIZE-1:0]   in_a,
  input  logic [OPERANDSIZE-1:0]   in_b,
  input  logic [TAGWIDTH-1:0]      in_tag,
  output logic [OPERANDSIZE-1:0]   alu_a,
  output logic [OPERANDSIZE-1:0]   alu_b,
  output logic [11:0]              alu_op,
  input  logic [OPERANDSIZE-1:0]   alu_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERANDSIZE-1:0]   out_q,
  output logic [TAGWIDTH-1:0]      out_tag,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 12 + 2 * OPERANDSIZE + TAGWIDTH;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [EW-1:0]          head;
  logic [11:0]            head_op;
  logic [OPERANDSIZE-1:0] head_a;
  logic [OPERANDSIZE-1:0] head_b;
  logic [TAGWIDTH-1:0]    head_tag;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = ~empty & (~out_valid | out_ready);

  assign head     = mem[rptr[AW-1:0]];
  assign head_op  = head[EW-1 -: 12];
  assign head_a   = head[EW-13 -: OPERANDSIZE];
  assign head_b   = head[TAGWIDTH +: OPERANDSIZE];
  assign head_tag = head[TAGWIDTH-1:0];

  // An empty queue drives zeros, which the ALU treats as ADD 0 + 0.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (!empty) begin
      alu_a  = head_a;
      alu_b  = head_b;
      alu_op = head_op;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {in_op, in_a, in_b, in_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Result fields hold their last value after the consumer drains them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_q       <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_q       <= alu_q;
      out_tag     <= head_tag;
      out_illegal <= (head_op > 12'd1);
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: bench-side ALU, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_alu_issue_queue;

  localparam int OS = 64;
  localparam int D  = 4;
  localparam int TW = 6;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [11:0]   in_op;
  logic [OS-1:0] in_a;
  logic [OS-1:0] in_b;
  logic [TW-1:0] in_tag;
  logic [OS-1:0] alu_a;
  logic [OS-1:0] alu_b;
  logic [11:0]   alu_op;
  logic [OS-1:0] alu_q;
  logic          out_valid;
  logic          out_ready;
  logic [OS-1:0] out_q;
  logic [TW-1:0] out_tag;
  logic          out_illegal;
  logic [2:0]    count;

  alu_issue_queue #(.OPERANDSIZE(OS), .DEPTH(D), .TAGWIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_q(alu_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_tag(out_tag), .out_illegal(out_illegal), .count(count)
  );

  // Combinational ALU: ADD, SUB, zero for anything else.
  always_comb begin
    case (alu_op)
      12'd0:   alu_q = alu_a + alu_b;
      12'd1:   alu_q = alu_a - alu_b;
      default: alu_q = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OS-1:0] q;
    logic [TW-1:0] tag;
    logic          ill;
  } res_t;

  res_t fifo[$];
  res_t wb;
  logic wb_v;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic step(input logic v, input logic [11:0] op, input logic [OS-1:0] a,
                      input logic [OS-1:0] b, input logic [TW-1:0] tag, input logic ordy);
    bit   do_push;
    bit   do_pop;
    res_t e;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, 64'(fifo.size() < D));
    chk("count", count, 64'(fifo.size()));
    chk("out_valid", out_valid, wb_v);
    if (wb_v) begin
      chk("out_q", out_q, wb.q);
      chk("out_tag", out_tag, wb.tag);
      chk("out_illegal", out_illegal, wb.ill);
    end
    do_push = v && (fifo.size() < D);
    do_pop  = (fifo.size() > 0) && (!wb_v || ordy);
    if (do_pop) begin
      wb   = fifo.pop_front();
      wb_v = 1'b1;
    end else if (wb_v && ordy) begin
      wb_v = 1'b0;
    end
    if (do_push) begin
      e.q   = (op == 12'd0) ? a + b : (op == 12'd1) ? a - b : '0;
      e.tag = tag;
      e.ill = (op > 12'd1);
      fifo.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 12'd0, '0, '0, '0, ordy);
  endtask

  initial begin
    logic [11:0] rop;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_tag = '0; out_ready = 1'b0;
    wb_v = 1'b0; wb.q = '0; wb.tag = '0; wb.ill = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD: 5 + 7 with tag 3.
    step(1'b1, 12'd0, 64'd5, 64'd7, 6'd3, 1'b1);
    idle(1'b1);
    chk("single_valid", out_valid, 1);
    chk("single_q", out_q, 12);
    chk("single_tag", out_tag, 3);
    chk("single_illegal", out_illegal, 0);
    chk("single_count", count, 0);
    idle(1'b1);
    idle(1'b1);

    // Fill under backpressure: one result held plus four queued.
    for (int i = 0; i < 5; i++)
      step(1'b1, 12'(i % 2), 64'(100 + i), 64'(i), 6'(10 + i), 1'b0);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    step(1'b1, 12'd0, 64'd999, 64'd1, 6'd20, 1'b0);
    chk("refused_count", count, 4);
    // Full queue with a pop: push refused this cycle, accepted next.
    step(1'b1, 12'd0, 64'd50, 64'd60, 6'd21, 1'b1);
    chk("fullpop_count", count, 3);
    step(1'b1, 12'd0, 64'd50, 64'd60, 6'd21, 1'b1);
    chk("fullpop_next_count", count, 3);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Illegal opcode sandwiched between two ADDs.
    step(1'b1, 12'd0,   64'd3, 64'd4, 6'd8,  1'b1);
    step(1'b1, 12'h00A, 64'd1, 64'd2, 6'd9,  1'b1);
    step(1'b1, 12'd0,   64'd6, 64'd6, 6'd10, 1'b1);
    chk("illegal_flag", out_illegal, 1);
    chk("illegal_tag", out_tag, 9);
    chk("illegal_q", out_q, 0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Asynchronous reset with work in flight.
    for (int i = 0; i < 4; i++)
      step(1'b1, 12'd1, 64'(200 + i), 64'd1, 6'(30 + i), 1'b0);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_q", out_q, 0);
    chk("arst_in_ready", in_ready, 1);
    fifo.delete();
    wb_v = 1'b0; wb.q = '0; wb.tag = '0; wb.ill = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 1000; i++) begin
      rop = ($urandom % 10 == 0) ? 12'($urandom) : 12'($urandom % 2);
      step(($urandom % 4) != 0, rop, {$urandom, $urandom}, {$urandom, $urandom},
           6'($urandom), ($urandom % 3) != 0);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("final_count", count, 0);
    chk("final_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
